rgb_pwm_fader: RTL and testbench

//  Downstream LED stage for the colour mixer. It takes a 3-bit colour code (bit2=R, bit1=G,
//  bit0=B) and drives the active-low RGB LED pins with per-channel 8-bit PWM.

---
 rtl/rgb_pwm_fader.sv | 131 +++++++++++++
 tb/tb_rgb_pwm_fader.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/rgb_pwm_fader.sv
// RGB LED driver: per-channel 8-bit PWM (active-low pins) with linear duty ramps
// toward a target set by a 3-bit colour code and a common brightness.
module rgb_pwm_fader #(
    parameter int CNT_W    = 8,
    parameter int STEP_DIV = 12000
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [2:0]       color_i,
    input  logic [CNT_W-1:0] brightness_i,
    output logic             LED_R,
    output logic             LED_G,
    output logic             LED_B,
    output logic             busy_o,
    output logic             done_o,
    output logic             dbg_state_o
);

    localparam int PS_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(STEP_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = '1;

    typedef enum logic {
        IDLE = 1'b0,
        FADE = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [PS_W-1:0]   presc_q, presc_d;
    logic [CNT_W-1:0]  pwm_cnt_q, pwm_cnt_d;
    // Channel index matches the colour bit: 2=R, 1=G, 0=B.
    logic [CNT_W-1:0]  tgt_q    [3];
    logic [CNT_W-1:0]  tgt_d    [3];
    logic [CNT_W-1:0]  duty_q   [3];
    logic [CNT_W-1:0]  duty_d   [3];
    logic [CNT_W-1:0]  shadow_q [3];
    logic [CNT_W-1:0]  shadow_d [3];
    logic [2:0]        led_q, led_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              tick;
    logic              any_diff;
    logic              all_eq_next;

    always_comb begin
        tick        = (state_q == FADE) && (presc_q == PS_LAST);
        any_diff    = 1'b0;
        all_eq_next = 1'b1;
        pwm_cnt_d   = pwm_cnt_q + 1'b1;
        for (int i = 0; i < 3; i++) begin
            tgt_d[i]  = color_i[i] ? brightness_i : '0;
            duty_d[i] = duty_q[i];
            // Ticks compare against the registered target, so a same-cycle retarget waits.
            if (tick) begin
                if (duty_q[i] < tgt_q[i]) begin
                    duty_d[i] = duty_q[i] + 1'b1;
                end else if (duty_q[i] > tgt_q[i]) begin
                    duty_d[i] = duty_q[i] - 1'b1;
                end
            end
            if (duty_q[i] != tgt_q[i]) begin
                any_diff = 1'b1;
            end
            if (duty_d[i] != tgt_q[i]) begin
                all_eq_next = 1'b0;
            end
            shadow_d[i] = (pwm_cnt_q == CNT_LAST) ? duty_q[i] : shadow_q[i];
            led_d[i]    = ~(pwm_cnt_q < shadow_q[i]);
        end

        state_d = state_q;
        presc_d = presc_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                presc_d = '0;
                if (any_diff) begin
                    state_d = FADE;
                end
            end
            FADE: begin
                presc_d = tick ? '0 : presc_q + 1'b1;
                if (tick && all_eq_next) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                presc_d = '0;
            end
        endcase
        busy_d = (state_d == FADE);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            pwm_cnt_q <= '0;
            led_q     <= 3'b111;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                tgt_q[i]    <= '0;
                duty_q[i]   <= '0;
                shadow_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            pwm_cnt_q <= pwm_cnt_d;
            led_q     <= led_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            for (int i = 0; i < 3; i++) begin
                tgt_q[i]    <= tgt_d[i];
                duty_q[i]   <= duty_d[i];
                shadow_q[i] <= shadow_d[i];
            end
        end
    end

    assign LED_R       = led_q[2];
    assign LED_G       = led_q[1];
    assign LED_B       = led_q[0];
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_rgb_pwm_fader.sv
// Directed bench for rgb_pwm_fader with STEP_DIV=4, CNT_W=8; expected values are hand-derived.
module tb_rgb_pwm_fader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] color;
    logic [7:0] bright;
    logic       LED_R, LED_G, LED_B, busy_o, done_o, dbg_state_o;

    int n_vec = 0;
    int n_err = 0;
    int done_cnt = 0;
    int busy_cnt = 0;
    int lit_cnt = 0;
    int g_at9, g_at10;

    rgb_pwm_fader #(.CNT_W(8), .STEP_DIV(4)) dut (
        .CLK(clk), .RST_N(rst_n), .color_i(color), .brightness_i(bright),
        .LED_R(LED_R), .LED_G(LED_G), .LED_B(LED_B),
        .busy_o(busy_o), .done_o(done_o), .dbg_state_o(dbg_state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (done_o === 1'b1) done_cnt++;
            if (busy_o === 1'b1) busy_cnt++;
            if ({LED_R, LED_G, LED_B} !== 3'b111) lit_cnt++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Counts low LED samples over one PWM period, cnt 0..255 as seen one clock later.
    task automatic measure_period(input int change_at, output int lr, output int lg, output int lb);
        int n;
        n = 0;
        lr = 0; lg = 0; lb = 0;
        while (dut.pwm_cnt_q != 8'd1 && n < 300) begin
            step_clk();
            n++;
        end
        check_eq("period_align_timeout", n < 300, 1);
        for (int i = 0; i < 256; i++) begin
            if (LED_R == 1'b0) lr++;
            if (LED_G == 1'b0) lg++;
            if (LED_B == 1'b0) lb++;
            if (dut.pwm_cnt_q == 8'd9) g_at9 = dut.duty_q[1];
            if (dut.pwm_cnt_q == 8'd10) g_at10 = dut.duty_q[1];
            if (i == change_at) color = 3'b000;
            step_clk();
        end
    endtask

    initial begin
        int n, lr, lg, lb, b0, d0, l0, bad_sum;
        g_at9 = -1;
        g_at10 = -1;

        // 1. reset held with full white requested
        rst_n = 1'b0; color = 3'b111; bright = 8'd255;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_eq("rst_leds", {LED_R, LED_G, LED_B}, 3'b111);
        check_eq("rst_busy", busy_o, 0);
        check_eq("rst_done", done_o, 0);
        check_eq("rst_duty_r", dut.duty_q[2], 0);

        // 4. no-op targets
        color = 3'b000;
        rst_n = 1'b1;
        b0 = busy_cnt; d0 = done_cnt; l0 = lit_cnt;
        repeat (40) step_clk();
        color = 3'b111; bright = 8'd0;
        repeat (40) step_clk();
        color = 3'b101;
        repeat (10) step_clk();
        check_eq("noop_busy", busy_cnt - b0, 0);
        check_eq("noop_done", done_cnt - d0, 0);
        check_eq("noop_leds", lit_cnt - l0, 0);

        // 2. red ramp
        color = 3'b100; bright = 8'd255;
        d0 = done_cnt;
        step_clk();
        check_eq("ramp_busy_1clk", busy_o, 0);
        step_clk();
        check_eq("ramp_busy_2clk", busy_o, 1);
        check_eq("ramp_state", dbg_state_o, 1);
        n = 2;
        while (done_o !== 1'b1 && n < 1100) begin
            step_clk();
            n++;
        end
        check_eq("ramp_clocks", n, 1022);
        check_eq("ramp_duty_r", dut.duty_q[2], 255);
        check_eq("ramp_busy_end", busy_o, 0);
        step_clk();
        check_eq("ramp_done_width", done_o, 0);
        check_eq("ramp_done_count", done_cnt - d0, 1);
        step_clk();
        measure_period(-1, lr, lg, lb);
        check_eq("ramp_pwm_r", lr, 255);
        check_eq("ramp_pwm_g", lg, 0);
        check_eq("ramp_pwm_b", lb, 0);

        // 3. retarget red->green from duty_R=100
        color = 3'b000;
        n = 0;
        while (dut.duty_q[2] != 8'd100 && n < 1100) begin
            step_clk();
            n++;
        end
        check_eq("retgt_reach100_timeout", n < 1100, 1);
        color = 3'b010;
        d0 = done_cnt;
        bad_sum = 0;
        n = 0;
        while (dut.duty_q[2] != 8'd0 && n < 600) begin
            step_clk();
            n++;
            if (int'(dut.duty_q[2]) + int'(dut.duty_q[1]) != 100) bad_sum++;
        end
        check_eq("retgt_r0_timeout", n < 600, 1);
        check_eq("retgt_lockstep", bad_sum, 0);
        check_eq("retgt_g_at_r0", dut.duty_q[1], 100);
        check_eq("retgt_busy_mid", busy_o, 1);
        check_eq("retgt_no_early_done", done_cnt - d0, 0);
        n = 0;
        while (done_o !== 1'b1 && n < 1100) begin
            step_clk();
            n++;
        end
        check_eq("retgt_done_timeout", n < 1100, 1);
        check_eq("retgt_end_g", dut.duty_q[1], 255);
        check_eq("retgt_end_r", dut.duty_q[2], 0);
        step_clk();
        check_eq("retgt_done_count", done_cnt - d0, 1);

        // 5. shadow boundary: green duty first drops at pwm_cnt=10
        step_clk();
        measure_period(3, lr, lg, lb);
        check_eq("shadow_g_at9", g_at9, 255);
        check_eq("shadow_g_at10", g_at10, 254);
        check_eq("shadow_old_period_g", lg, 255);
        check_eq("shadow_old_period_r", lr, 0);
        measure_period(-1, lr, lg, lb);
        check_eq("shadow_new_period_g", lg, 193);
        n = 0;
        while (done_o !== 1'b1 && n < 1100) begin
            step_clk();
            n++;
        end
        check_eq("shadow_fade_done_timeout", n < 1100, 1);
        check_eq("shadow_fade_end_g", dut.duty_q[1], 0);

        // 6. asynchronous reset mid-fade, then fresh ramp
        color = 3'b111; bright = 8'd255;
        repeat (40) step_clk();
        check_eq("mid_busy", busy_o, 1);
        check_eq("mid_duty_r", dut.duty_q[2], 9);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_eq("arst_leds", {LED_R, LED_G, LED_B}, 3'b111);
        check_eq("arst_busy", busy_o, 0);
        check_eq("arst_done", done_o, 0);
        check_eq("arst_duty_r", dut.duty_q[2], 0);
        check_eq("arst_duty_g", dut.duty_q[1], 0);
        check_eq("arst_state", dbg_state_o, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step_clk();
        check_eq("rearm_busy_1clk", busy_o, 0);
        step_clk();
        check_eq("rearm_busy_2clk", busy_o, 1);
        repeat (4) step_clk();
        check_eq("rearm_duty_r", dut.duty_q[2], 1);
        check_eq("rearm_duty_g", dut.duty_q[1], 1);
        check_eq("rearm_duty_b", dut.duty_q[0], 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
